// File: rtl/pipeline_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply-divide unit; the EX-stage decoder and
// hazard unit import the same op codes so all three agree on i_op meaning.
package pipeline_muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  // 0x80000000 maps onto itself, which is still the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    return negate_if(v, is_signed && v[XLEN-1]);
  endfunction

endpackage

// File: rtl/pipeline_muldiv.sv
// Iterative MIPS-style HI/LO unit: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes, with a single sign-fix cycle before commit.
module pipeline_muldiv
  import pipeline_muldiv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_data_A,
  input  logic [XLEN-1:0] i_data_B,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_div_zero,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  muldiv_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  operand_b;
  logic             is_div;
  logic             neg_main;
  logic             neg_rem;

  logic              is_mul_op;
  logic              is_div_op;
  logic              op_signed;
  logic              accept;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;

  // acc_hi/acc_lo double as {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    is_mul_op   = (i_op == OP_MULT) || (i_op == OP_MULTU);
    is_div_op   = (i_op == OP_DIV)  || (i_op == OP_DIVU);
    op_signed   = (i_op == OP_MULT) || (i_op == OP_DIV);
    accept      = i_start && !i_flush;
    mag_a       = magnitude(i_data_A, op_signed);
    mag_b       = magnitude(i_data_B, op_signed);
    mul_addend  = acc_lo[0] ? operand_b : {XLEN{1'b0}};
    mul_sum     = {1'b0, acc_hi} + {1'b0, mul_addend};
    div_shift   = {acc_hi, acc_lo[XLEN-1]};
    div_diff    = div_shift - {1'b0, operand_b};
    product     = {acc_hi, acc_lo};
    product_fix = neg_main ? -product : product;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      operand_b  <= '0;
      is_div     <= 1'b0;
      neg_main   <= 1'b0;
      neg_rem    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (accept) begin
            if (is_div_op && (i_data_B == '0)) begin
              state      <= ST_DONE;
              o_done     <= 1'b1;
              o_div_zero <= 1'b1;
            end else if (is_mul_op || is_div_op) begin
              state     <= ST_CALC;
              o_busy    <= 1'b1;
              cnt       <= '0;
              is_div    <= is_div_op;
              neg_main  <= op_signed && (i_data_A[XLEN-1] ^ i_data_B[XLEN-1]);
              neg_rem   <= op_signed && is_div_op && i_data_A[XLEN-1];
              acc_hi    <= '0;
              acc_lo    <= is_div_op ? mag_a : mag_b;
              operand_b <= is_div_op ? mag_b : mag_a;
            end else if (i_op == OP_MTHI) begin
              o_hi <= i_data_A;
            end else if (i_op == OP_MTLO) begin
              o_lo <= i_data_A;
            end
          end
        end

        ST_CALC: begin
          if (i_flush) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITERATIONS - 1)) begin
              state <= ST_FIX;
            end
            if (is_div) begin
              if (div_diff[XLEN]) begin
                acc_hi <= div_shift[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
              end else begin
                acc_hi <= div_diff[XLEN-1:0];
                acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
              end
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
            end
          end
        end

        ST_FIX: begin
          o_busy <= 1'b0;
          if (i_flush) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_DONE;
            o_done <= 1'b1;
            if (is_div) begin
              o_hi <= negate_if(acc_hi, neg_rem);
              o_lo <= negate_if(acc_lo, neg_main);
            end else begin
              {o_hi, o_lo} <= product_fix;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Self-checking bench for pipeline_muldiv: directed literal cases plus random
// traffic compared every cycle against a cycle-count/arithmetic reference model.
module tb_pipeline_muldiv;

  localparam logic [2:0] T_MULT  = 3'b000;
  localparam logic [2:0] T_MULTU = 3'b001;
  localparam logic [2:0] T_DIV   = 3'b010;
  localparam logic [2:0] T_DIVU  = 3'b011;
  localparam logic [2:0] T_MTHI  = 3'b100;
  localparam logic [2:0] T_MTLO  = 3'b101;
  localparam int         BUSY_CYCLES = 33;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic [2:0]  op     = 3'b000;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_muldiv dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_data_A   (data_a),
    .i_data_B   (data_b),
    .i_flush    (flush),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  function automatic void model_result(input logic [2:0] f_op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] r_hi,
                                       output logic [31:0] r_lo);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    logic        [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r_hi = '0;
    r_lo = '0;
    case (f_op)
      T_MULT: begin
        sp = sa * sb;
        r_hi = sp[63:32];
        r_lo = sp[31:0];
      end
      T_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        r_hi = up[63:32];
        r_lo = up[31:0];
      end
      T_DIV: begin
        sp = sa / sb;
        r_lo = sp[31:0];
        sp = sa % sb;
        r_hi = sp[31:0];
      end
      default: begin
        r_lo = a / b;
        r_hi = a % b;
      end
    endcase
  endfunction

  // Reference model: an accepted op keeps the unit busy for a fixed cycle count,
  // then commits its arithmetic result; everything else is immediate.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dz   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        if (op <= T_DIVU) begin
          if ((op == T_DIV || op == T_DIVU) && data_b == '0) begin
            m_done = 1'b1; m_dz = 1'b1;
          end else begin
            model_result(op, data_a, data_b, p_hi, p_lo);
            m_left = BUSY_CYCLES;
          end
        end else if (op == T_MTHI) begin
          m_hi = data_a;
        end else if (op == T_MTLO) begin
          m_lo = data_a;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (busy !== (m_left > 0) || done !== m_done || div_zero !== m_dz ||
          hi !== m_hi || lo !== m_lo) begin
        n_err++;
        $display("[TB] FAIL cycle_compare t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h expected busy=%b done=%b dz=%b hi=%h lo=%h",
                 $time, busy, done, div_zero, hi, lo, (m_left > 0), m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic f);
    @(negedge clk);
    start = s; op = o; data_a = a; data_b = b; flush = f;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
  endtask

  // k counts edges after the accepting edge; done is seen in the cycle that edge opens.
  task automatic waitDone(input int budget, output int edges, output int busy_cycles, output bit found);
    edges = -1; busy_cycles = 0; found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        edges = k; found = 1'b1;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_edges,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int e, bc;
    bit f;
    applyStimulus(1'b1, o, a, b, 1'b0);
    waitDone(60, e, bc, f);
    checkOutput({name, "_latency"}, 64'(e), 64'(exp_edges));
    checkOutput({name, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
    checkOutput({name, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
  endtask

  initial begin
    int e, bc, cnt_done;
    bit f;
    logic [31:0] ra, rb;

    #12;
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    checkOutput("reset_dz",   {63'b0, div_zero}, 64'd0);
    checkOutput("reset_hi",   {32'b0, hi}, 64'd0);
    checkOutput("reset_lo",   {32'b0, lo}, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    runOp("mult", T_MULT, 32'hFFFFFFFF, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFE);

    applyStimulus(1'b1, T_MULTU, 32'hFFFFFFFF, 32'h2, 1'b0);
    waitDone(60, e, bc, f);
    checkOutput("multu_busy_cycles", 64'(bc), 64'd33);
    checkOutput("multu_hi", {32'b0, hi}, 64'h1);
    checkOutput("multu_lo", {32'b0, lo}, 64'hFFFFFFFE);

    runOp("div_neg7_2", T_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divu_100_7", T_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    applyStimulus(1'b1, T_MTHI, 32'h11, 32'h0, 1'b0);
    applyStimulus(1'b1, T_MTLO, 32'h22, 32'h0, 1'b0);
    checkOutput("mt_busy", {63'b0, busy}, 64'd0);
    checkOutput("mthi_hi", {32'b0, hi}, 64'h11);
    applyStimulus(1'b1, T_DIVU, 32'd100, 32'd0, 1'b0);
    waitDone(10, e, bc, f);
    checkOutput("divzero_latency", 64'(e), 64'd0);
    checkOutput("divzero_flag", {63'b0, div_zero}, 64'd1);
    checkOutput("divzero_hi", {32'b0, hi}, 64'h11);
    checkOutput("divzero_lo", {32'b0, lo}, 64'h22);

    runOp("div_min_neg1", T_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);

    applyStimulus(1'b1, T_MULT, 32'h12345678, 32'h9, 1'b0);
    repeat (9) @(posedge clk);
    applyStimulus(1'b0, T_MULT, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput("flush_busy", {63'b0, busy}, 64'd0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    checkOutput("flush_no_done", 64'(cnt_done), 64'd0);
    checkOutput("flush_hi", {32'b0, hi}, 64'h0);
    checkOutput("flush_lo", {32'b0, lo}, 64'h80000000);
    applyStimulus(1'b1, T_MTLO, 32'hCAFEBABE, 32'h0, 1'b0);
    checkOutput("mtlo_after_flush", {32'b0, lo}, 64'hCAFEBABE);

    applyStimulus(1'b1, T_MULT, 32'd7, 32'hFFFFFFFD, 1'b0);
    repeat (4) @(posedge clk);
    applyStimulus(1'b1, T_MULT, 32'd5, 32'd5, 1'b0);
    cnt_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    checkOutput("busy_start_single_done", 64'(cnt_done), 64'd1);
    checkOutput("busy_start_hi", {32'b0, hi}, 64'hFFFFFFFF);
    checkOutput("busy_start_lo", {32'b0, lo}, 64'hFFFFFFEB);

    applyStimulus(1'b1, T_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {63'b0, busy}, 64'd0);
    checkOutput("midreset_done", {63'b0, done}, 64'd0);
    checkOutput("midreset_dz",   {63'b0, div_zero}, 64'd0);
    checkOutput("midreset_hi",   {32'b0, hi}, 64'd0);
    checkOutput("midreset_lo",   {32'b0, lo}, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    runOp("multu_after_reset", T_MULTU, 32'd3, 32'd5, 33, 32'd0, 32'd15);

    for (int i = 0; i < 4000; i++) begin
      case ($urandom % 4)
        0: ra = 32'h80000000;
        1: ra = $urandom % 16;
        default: ra = $urandom;
      endcase
      case ($urandom % 8)
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = ($urandom % 9) + 1;
        default: rb = $urandom;
      endcase
      applyStimulus(($urandom % 3) == 0, 3'($urandom % 8), ra, rb, ($urandom % 40) == 0);
    end
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
